// File: rtl/mem_pkg.sv
// ============================================================================
// Package   : mem_pkg
// Purpose   : Shared types and constants for the load/store front end
//             (bus width codes, RV32 funct3 size codes, error codes, FSM states)
//             plus small request-classification helpers.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // Transfer size as presented on the bus
  typedef enum logic [1:0] {
    WB_B = 2'b00,
    WB_H = 2'b01,
    WB_W = 2'b10
  } wb_width_t;

  // RV32 load/store size and sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Response error codes
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } mem_err_t;

  // Front-end control states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_RESP = 2'b10
  } mau_state_t;

  // Unknown size codes, and unsigned variants used with a store, are illegal
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Halfwords need an even address, words a 4-byte-aligned one
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wishbone_if.sv
// ============================================================================
// Interface : WISHBONE_IF
// Purpose   : Single-master bus bundle between the memory front end and
//             RAMBlock / other slaves. Byte placement is the slave's job.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface WISHBONE_IF (
  input logic iClk,
  input logic nRst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  width;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        ack;

  modport master (
    input  iClk, nRst, data_read, ack,
    output cyc, stb, we, addr, width, data_write
  );

  modport slave (
    input  iClk, nRst, cyc, stb, we, addr, width, data_write,
    output data_read, ack
  );

endinterface

`default_nettype wire

// File: rtl/mem_load_extend.sv
// ============================================================================
// Module    : mem_load_extend
// Purpose   : Combinational load-data extension. Takes LSB-aligned bus read
//             data and sign- or zero-extends it according to the RV32 funct3.
//             Shared with the instruction-fetch side.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data_read,
  output logic [31:0] rdata
);

  // Select extension by size/sign code; words and anything else pass through
  always_comb begin
    rdata = data_read;
    case (funct3)
      F3_B:    rdata = {{24{data_read[7]}},  data_read[7:0]};
      F3_H:    rdata = {{16{data_read[15]}}, data_read[15:0]};
      F3_BU:   rdata = {24'h000000, data_read[7:0]};
      F3_HU:   rdata = {16'h0000,   data_read[15:0]};
      default: rdata = data_read;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module    : mem_access_unit
// Purpose   : Load/store front end between the CPU memory stage and a
//             WISHBONE master port. One request at a time: classify, run one
//             bus cycle with a bounded ack wait, return extended data or an
//             error code as a one-cycle response strobe.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_err_code,
  WISHBONE_IF.master  mem_wb
);

  // Counter just wide enough to reach TIMEOUT-1
  localparam int              CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  mau_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;

  logic             r_cyc;
  logic             r_stb;
  logic             r_we;
  logic [31:0]      r_addr;
  wb_width_t        r_width;
  logic [31:0]      r_wdata;

  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;
  mem_err_t         r_rsp_code;

  logic             w_illegal;
  logic             w_misalign;
  logic [31:0]      w_ext_rdata;

  // Request classification; illegal funct3 outranks misalignment
  assign w_illegal  = f3_illegal(req_funct3, req_we);
  assign w_misalign = f3_misaligned(req_funct3, req_addr[1:0]);

  assign req_ready  = (r_state == S_IDLE);

  // The low address bits stay on the held bus address, so extension only
  // needs funct3 and the LSB-aligned read data
  mem_load_extend u_extend (
    .funct3    (r_funct3),
    .data_read (mem_wb.data_read),
    .rdata     (w_ext_rdata)
  );

  // Control FSM, bus output registers, timeout counter and response registers
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_funct3    <= 3'b000;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_width     <= WB_B;
      r_wdata     <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_rsp_code  <= ERR_NONE;
    end else begin
      // Strobe is single-cycle; data/err/code hold their last value
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_illegal) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= 32'h0;
              r_rsp_err   <= 1'b1;
              r_rsp_code  <= ERR_FUNCT3;
            end else if (w_misalign) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= 32'h0;
              r_rsp_err   <= 1'b1;
              r_rsp_code  <= ERR_MISALIGN;
            end else begin
              r_state  <= S_BUS;
              r_cnt    <= '0;
              r_funct3 <= req_funct3;
              r_cyc    <= 1'b1;
              r_stb    <= 1'b1;
              r_we     <= req_we;
              r_addr   <= req_addr;
              r_width  <= wb_width_t'(req_funct3[1:0]);
              r_wdata  <= req_wdata;
            end
          end
        end

        S_BUS: begin
          // Ack is checked first so a last-cycle ack still completes normally
          if (mem_wb.ack) begin
            r_state     <= S_RESP;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_we ? 32'h0 : w_ext_rdata;
            r_rsp_err   <= 1'b0;
            r_rsp_code  <= ERR_NONE;
          end else if (r_cnt == c_cnt_last) begin
            r_state     <= S_RESP;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b1;
            r_rsp_code  <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_wb.cyc        = r_cyc;
  assign mem_wb.stb        = r_stb;
  assign mem_wb.we         = r_we;
  assign mem_wb.addr       = r_addr;
  assign mem_wb.width      = r_width;
  assign mem_wb.data_write = r_wdata;

  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign rsp_err_code = r_rsp_code;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module    : tb_mem_access_unit
// Purpose   : Self-checking bench for mem_access_unit with a byte-addressed
//             slave, a byte-array reference model and a response scoreboard.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int NO_ACK  = 1000;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_err_code;

  always #5 clk = ~clk;

  WISHBONE_IF wb (.iClk(clk), .nRst(nRst));

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .iClk         (clk),
    .nRst         (nRst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .rsp_err_code (rsp_err_code),
    .mem_wb       (wb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave: byte memory, LSB-aligned data, delayed ack -------
  logic [7:0] smem [256];
  logic       mem_clear = 1'b1;
  int         ack_wait = 0;
  int         bus_cycles = 0;

  always_comb begin
    logic [7:0] a;
    a = wb.addr[7:0];
    wb.data_read = {smem[a + 8'd3], smem[a + 8'd2], smem[a + 8'd1], smem[a]};
    wb.ack = wb.cyc && wb.stb && (bus_cycles >= ack_wait);
  end

  always @(posedge clk) begin
    bus_cycles <= wb.cyc ? bus_cycles + 1 : 0;
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) smem[i] <= 8'h00;
    end else if (wb.cyc && wb.stb && wb.ack && wb.we) begin
      smem[wb.addr[7:0]] <= wb.data_write[7:0];
      if (wb.width != 2'b00) smem[wb.addr[7:0] + 8'd1] <= wb.data_write[15:8];
      if (wb.width == 2'b10) begin
        smem[wb.addr[7:0] + 8'd2] <= wb.data_write[23:16];
        smem[wb.addr[7:0] + 8'd3] <= wb.data_write[31:24];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
  } rsp_t;

  rsp_t exp_q[$];

  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [1:0]  exp_width = 2'b00;
  logic [31:0] exp_wdata = 32'h0;

  always @(negedge clk) begin : mon_rsp
    rsp_t e;
    if (nRst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, expected none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_err_code", 32'(rsp_err_code), 32'(e.code));
        check("req_ready_in_resp", 32'(req_ready), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_bus
    if (nRst && wb.cyc) begin
      check("bus_stb", 32'(wb.stb), 32'd1);
      check("bus_we", 32'(wb.we), 32'(exp_we));
      check("bus_addr", wb.addr, exp_addr);
      check("bus_width", 32'(wb.width), 32'(exp_width));
      check("bus_data_write", wb.data_write, exp_wdata);
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] model_mem [256];

  function automatic int f3_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int aw);
    rsp_t   e;
    int     size, lat, cyc_n, exp_lat, exp_cyc;
    bit     ill, mis, tmo;
    longint val;
    size = f3_size(f3);
    ill  = (size == 0) || (we && f3 >= 3'd4);
    mis  = !ill && ((addr % size) != 0);
    tmo  = !ill && !mis && (aw >= TIMEOUT);
    e    = '0;
    if (ill)      begin e.err = 1'b1; e.code = 2'd2; end
    else if (mis) begin e.err = 1'b1; e.code = 2'd1; end
    else if (tmo) begin e.err = 1'b1; e.code = 2'd3; end
    else if (we) begin
      for (int i = 0; i < size; i++) model_mem[addr[7:0] + i] = wdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val += longint'(model_mem[addr[7:0] + i]) << (8 * i);
      if (f3 < 3'd4 && size < 4 && val >= (longint'(1) << (8 * size - 1)))
        val -= (longint'(1) << (8 * size));
      e.rdata = val[31:0];
    end
    exp_lat = (ill || mis) ? 1 : (tmo ? TIMEOUT + 1 : aw + 2);
    exp_cyc = (ill || mis) ? 0 : (tmo ? TIMEOUT : aw + 1);

    wait_ready();
    exp_we    = we;
    exp_addr  = addr;
    exp_width = f3[1:0];
    exp_wdata = wdata;
    ack_wait  = aw;
    exp_q.push_back(e);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0;
    cyc_n = 0;
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      if (wb.cyc) cyc_n++;
      if (rsp_valid) break;
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("cyc_cycles", 32'(cyc_n), 32'(exp_cyc));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    nRst = 1'b0;
    repeat (3) @(posedge clk);
    mem_clear = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_cyc", 32'(wb.cyc), 32'd0);
    check("reset_stb", 32'(wb.stb), 32'd0);
    check("reset_we", 32'(wb.we), 32'd0);
    check("reset_addr", wb.addr, 32'h0);
    check("reset_width", 32'(wb.width), 32'd0);
    check("reset_data_write", wb.data_write, 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_code", 32'(rsp_err_code), 32'd0);
    nRst = 1'b1;

    do_req(1'b1, F3_W,  32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, F3_W,  32'h10, 32'h0, 0);
    do_req(1'b1, F3_B,  32'h21, 32'h80, 0);
    do_req(1'b0, F3_B,  32'h21, 32'h0, 0);
    do_req(1'b0, F3_BU, 32'h21, 32'h0, 0);
    do_req(1'b1, F3_H,  32'h30, 32'h8001, 0);
    do_req(1'b0, F3_H,  32'h30, 32'h0, 0);
    do_req(1'b0, F3_HU, 32'h30, 32'h0, 0);
    do_req(1'b0, F3_W,  32'h12, 32'h0, 0);
    do_req(1'b0, F3_H,  32'h13, 32'h0, 0);
    do_req(1'b1, F3_BU, 32'h40, 32'h55, 0);
    do_req(1'b1, 3'b011, 32'h41, 32'h0, 0);
    do_req(1'b0, F3_W,  32'h10, 32'h0, NO_ACK);
    do_req(1'b0, F3_W,  32'h10, 32'h0, TIMEOUT - 1);

    // Reset in the middle of a bus cycle: no response may follow
    wait_ready();
    exp_we = 1'b0; exp_addr = 32'h20; exp_width = 2'b10; exp_wdata = 32'h0;
    ack_wait = NO_ACK;
    req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check("rst_bus_cyc", 32'(wb.cyc), 32'd0);
    check("rst_bus_stb", 32'(wb.stb), 32'd0);
    check("rst_bus_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    ack_wait = 0;
    @(posedge clk);
    #1 check("rst_release_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Randomized traffic, mostly legal, with occasional slow or absent acks
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = ($urandom_range(0, 1) != 0) ? F3_W : 3'($urandom_range(0, 5));
      a = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 8'($urandom)};
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), f3, a, $urandom,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 17)) : 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
